// File: rtl/id_stage.sv
// id_stage: IF/ID register, register file and early branch/jump resolution.
// Optional ID_FORWARD_EN selects ALUOutM as the branch compare operands.
module id_stage (
    input  logic        CLK,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] IR,
    input  logic [31:0] PCPlus4F,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic [31:0] ALUOutM,
    input  logic        ForwardAD,
    input  logic        ForwardBD,
    output logic        PCSrcD,
    output logic        JumpD,
    output logic [31:0] PCBranchD,
    output logic [31:0] PCJumpD,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [4:0]  RsD,
    output logic [4:0]  RtD,
    output logic [4:0]  RdD,
    output logic [31:0] SignImmD
);

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;

    logic [31:0] rf [32];
    logic [5:0]  op;
    logic        is_beq;
    logic        is_bne;
    logic        is_jmp;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        flush;

    assign op       = InstrD[31:26];
    assign RsD      = InstrD[25:21];
    assign RtD      = InstrD[20:16];
    assign RdD      = InstrD[15:11];
    assign SignImmD = {{16{InstrD[15]}}, InstrD[15:0]};

    // Register file read ports with same-cycle write-through
    always_comb begin
        RD1D = 32'd0;
        RD2D = 32'd0;
        if (RsD != 5'd0) begin
            if (RegWriteW && (WriteRegW == RsD))
                RD1D = ResultW;
            else
                RD1D = rf[RsD];
        end
        if (RtD != 5'd0) begin
            if (RegWriteW && (WriteRegW == RtD))
                RD2D = ResultW;
            else
                RD2D = rf[RtD];
        end
    end

`ifdef ID_FORWARD_EN
    assign cmp_a = ForwardAD ? ALUOutM : RD1D;
    assign cmp_b = ForwardBD ? ALUOutM : RD2D;
`else
    assign cmp_a = RD1D;
    assign cmp_b = RD2D;

    logic unused_fwd;
    assign unused_fwd = ^{ALUOutM, ForwardAD, ForwardBD};
`endif

    // Opcode decode and early branch/jump resolution
    always_comb begin
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_jmp = 1'b0;
        unique case (op)
            OP_BEQ:         is_beq = 1'b1;
            OP_BNE:         is_bne = 1'b1;
            OP_J, OP_JAL:   is_jmp = 1'b1;
            default:        ;
        endcase
    end

    assign PCSrcD    = ValidD & ((is_beq & (cmp_a == cmp_b)) |
                                 (is_bne & (cmp_a != cmp_b)));
    assign JumpD     = ValidD & is_jmp;
    assign flush     = PCSrcD | JumpD;
    assign PCBranchD = PCPlus4D + {SignImmD[29:0], 2'b00};
    assign PCJumpD   = {PCPlus4D[31:28], InstrD[25:0], 2'b00};

    // IF/ID pipeline register: stall holds, redirect squashes wrong-path fetch
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            InstrD   <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (stall) begin
            InstrD   <= InstrD;
            PCPlus4D <= PCPlus4D;
            ValidD   <= ValidD;
        end else if (flush) begin
            InstrD   <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else begin
            InstrD   <= IR;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // Register file write port; $0 is never written
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (RegWriteW && (WriteRegW != 5'd0)) begin
            rf[WriteRegW] <= ResultW;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors for id_stage.
// Expected values are hand-computed from the instruction encodings.
module tb_id_stage;

    logic        CLK;
    logic        reset;
    logic        stall;
    logic [31:0] IR;
    logic [31:0] PCPlus4F;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [31:0] ALUOutM;
    logic        ForwardAD;
    logic        ForwardBD;
    logic        PCSrcD;
    logic        JumpD;
    logic [31:0] PCBranchD;
    logic [31:0] PCJumpD;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic [4:0]  RdD;
    logic [31:0] SignImmD;

    int vectors;
    int miscompares;

    id_stage dut (
        .CLK       (CLK),
        .reset     (reset),
        .stall     (stall),
        .IR        (IR),
        .PCPlus4F  (PCPlus4F),
        .RegWriteW (RegWriteW),
        .WriteRegW (WriteRegW),
        .ResultW   (ResultW),
        .ALUOutM   (ALUOutM),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .PCSrcD    (PCSrcD),
        .JumpD     (JumpD),
        .PCBranchD (PCBranchD),
        .PCJumpD   (PCJumpD),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .RD1D      (RD1D),
        .RD2D      (RD2D),
        .RsD       (RsD),
        .RtD       (RtD),
        .RdD       (RdD),
        .SignImmD  (SignImmD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic exp_fwd;
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b1;
        stall     = 1'b0;
        IR        = 32'd0;
        PCPlus4F  = 32'd0;
        RegWriteW = 1'b0;
        WriteRegW = 5'd0;
        ResultW   = 32'd0;
        ALUOutM   = 32'd0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        #12;
        chk("rst_instr", InstrD, 32'd0);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        chk("rst_pcplus4", PCPlus4D, 32'd0);
        chk("rst_pcsrc", {31'd0, PCSrcD}, 32'd0);
        reset = 1'b0;

        // addi $8,$0,5
        IR       = 32'h20080005;
        PCPlus4F = 32'h4;
        step();
        chk("addi_instr", InstrD, 32'h20080005);
        chk("addi_valid", {31'd0, ValidD}, 32'd1);
        chk("addi_rs", {27'd0, RsD}, 32'd0);
        chk("addi_rt", {27'd0, RtD}, 32'd8);
        chk("addi_imm", SignImmD, 32'd5);
        chk("addi_pc4", PCPlus4D, 32'h4);

        // writes $8 = 7, $9 = 7
        IR        = 32'd0;
        RegWriteW = 1'b1;
        WriteRegW = 5'd8;
        ResultW   = 32'd7;
        step();
        WriteRegW = 5'd9;
        step();
        RegWriteW = 1'b0;

        // beq $8,$9,+3 at PCPlus4 0x10
        IR       = 32'h11090003;
        PCPlus4F = 32'h10;
        step();
        chk("beq_rd1", RD1D, 32'd7);
        chk("beq_rd2", RD2D, 32'd7);
        chk("beq_pcsrc", {31'd0, PCSrcD}, 32'd1);
        chk("beq_target", PCBranchD, 32'h1C);
        chk("beq_nojump", {31'd0, JumpD}, 32'd0);
        IR       = 32'hDEADBEEF;
        PCPlus4F = 32'h14;
        step();
        chk("beq_flush_instr", InstrD, 32'd0);
        chk("beq_flush_valid", {31'd0, ValidD}, 32'd0);
        chk("bubble_pcsrc", {31'd0, PCSrcD}, 32'd0);

        // j with target field 0x40 at PCPlus4 0x8
        IR       = 32'h08000040;
        PCPlus4F = 32'h8;
        step();
        chk("j_jump", {31'd0, JumpD}, 32'd1);
        chk("j_target", PCJumpD, 32'h100);
        IR       = 32'h12345678;
        PCPlus4F = 32'hC;
        step();
        chk("j_flush_valid", {31'd0, ValidD}, 32'd0);
        chk("j_flush_instr", InstrD, 32'd0);

        // bne $8,$9 with equal operands: not taken
        IR       = 32'h15090002;
        PCPlus4F = 32'h20;
        step();
        chk("bne_eq_pcsrc", {31'd0, PCSrcD}, 32'd0);
        IR       = 32'h00000020;
        PCPlus4F = 32'h24;
        step();
        chk("bne_noflush", InstrD, 32'h00000020);
        chk("bne_noflush_v", {31'd0, ValidD}, 32'd1);

        // taken beq held by stall, flush on release
        IR       = 32'h11090003;
        PCPlus4F = 32'h30;
        step();
        chk("stall_beq_pcsrc", {31'd0, PCSrcD}, 32'd1);
        stall    = 1'b1;
        IR       = 32'h12345678;
        PCPlus4F = 32'h34;
        step();
        chk("stall_hold_instr", InstrD, 32'h11090003);
        chk("stall_hold_pc4", PCPlus4D, 32'h30);
        chk("stall_hold_valid", {31'd0, ValidD}, 32'd1);
        stall = 1'b0;
        step();
        chk("release_flush", InstrD, 32'd0);
        chk("release_valid", {31'd0, ValidD}, 32'd0);

        // $0 stays zero
        IR        = 32'd0;
        RegWriteW = 1'b1;
        WriteRegW = 5'd0;
        ResultW   = 32'hFFFFFFFF;
        step();
        chk("r0_wt", RD1D, 32'd0);
        RegWriteW = 1'b0;
        step();
        chk("r0_read", RD1D, 32'd0);

        // same-cycle write-through of $5
        IR = 32'h00A00000;
        step();
        chk("r5_before", RD1D, 32'd0);
        RegWriteW = 1'b1;
        WriteRegW = 5'd5;
        ResultW   = 32'h1234;
        #1;
        chk("r5_wt", RD1D, 32'h1234);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("r5_stored", RD1D, 32'h1234);

        // $1 = 1, $2 = 9, then beq $1,$2 with ALUOutM forwarded to A
        IR        = 32'd0;
        RegWriteW = 1'b1;
        WriteRegW = 5'd1;
        ResultW   = 32'd1;
        step();
        WriteRegW = 5'd2;
        ResultW   = 32'd9;
        step();
        RegWriteW = 1'b0;
        IR        = 32'h10220001;
        PCPlus4F  = 32'h40;
        ALUOutM   = 32'd9;
        ForwardAD = 1'b1;
        step();
        chk("fwd_rd1", RD1D, 32'd1);
        chk("fwd_rd2", RD2D, 32'd9);
`ifdef ID_FORWARD_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        chk("fwd_pcsrc", {31'd0, PCSrcD}, {31'd0, exp_fwd});
        ForwardAD = 1'b0;
        ALUOutM   = 32'd0;

        // negative offset wraps around zero
        IR       = 32'h1000FFF0;
        PCPlus4F = 32'h8;
        step();
        chk("wrap_target", PCBranchD, 32'hFFFFFFC8);
        chk("wrap_taken", {31'd0, PCSrcD}, 32'd1);

        // asynchronous reset mid-operation
        #2;
        reset = 1'b1;
        #1;
        chk("async_pcsrc", {31'd0, PCSrcD}, 32'd0);
        chk("async_instr", InstrD, 32'd0);
        chk("async_target", PCBranchD, 32'd0);
        chk("async_rd2", RD2D, 32'd0);
        reset = 1'b0;
        IR    = 32'h00400000;
        step();
        chk("rf_cleared", RD1D, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
